sync_width_conv_fifo: RTL and testbench
=======================================

Name: sync_width_conv_fifo

Overview:
Single-clock FIFO that converts data width between writer and reader, with any integer ratio in either direction.
- Storage is an array of DEPTH words, each BRAM_WIDTH bits wide.
- Exposes occupancy, programmable almost-full/almost-empty flags and a synchronous flush.
- Used inside one clock domain of the NoC, e.g. packing 32-bit flits into 64-bit beats ahead of a link.

Parameters:
WIDTH_IN, 32, write data width; integer multiple of BRAM_WIDTH
WIDTH_OUT, 64, read data width; integer multiple of BRAM_WIDTH
BRAM_WIDTH, 32, storage word width
DEPTH, 16, storage words; power of 2; divisible by WORDS_IN = WIDTH_IN/BRAM_WIDTH and WORDS_OUT = WIDTH_OUT/BRAM_WIDTH
AF_LEVEL, 12, almost_full threshold in words
AE_LEVEL, 2, almost_empty threshold in words

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
flush  in  1  synchronous clear of all contents
data_wr  in  WIDTH_IN  write data
valid_wr  in  1  write request
ready_wr  out  1  space available for one input beat
data_rd  out  WIDTH_OUT  read data, first-word-fall-through
valid_rd  out  1  one full output beat available
ready_rd  in  1  reader accepts beat
level  out  $clog2(DEPTH)+1  stored words
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL

Behaviour:
- State registers: wrptr, rdptr (each $clog2(DEPTH) bits, wrap modulo DEPTH) and level ($clog2(DEPTH)+1 bits). All reset to 0 asynchronously.
- Outputs while rst is high: ready_wr=0, valid_rd=0, level=0, almost_full=0, almost_empty=1 (assuming AE_LEVEL>=0). data_rd is don't-care when valid_rd=0.
- ready_wr = ~rst & (DEPTH-level >= WORDS_IN).
- valid_rd = ~rst & (level >= WORDS_OUT).
- A write fires on valid_wr & ready_wr. Input word k (bits k*BRAM_WIDTH upward, k=0 is the LSBs) goes to address wrptr+k. Then wrptr += WORDS_IN.
- A read fires on valid_rd & ready_rd. Then rdptr += WORDS_OUT.
- data_rd word j is driven combinationally from storage[rdptr+j], so word 0 of the output is the oldest stored word.
- Latency: a write in cycle N can raise valid_rd in cycle N+1. No bypass path within the same cycle.
- Simultaneous fire: both operations take effect; level_next = level + WORDS_IN - WORDS_OUT. This is legal even when full or empty, provided each side's own condition holds.
- valid_wr while ready_wr=0: ignored, no state change. The writer must hold data. valid_wr may wait on ready_wr; ready_wr never depends on valid_wr.
- Once valid_rd=1, it stays high until a read fires or flush/rst occurs.
- flush: the next edge sets wrptr=rdptr=level=0. It has priority over a concurrent write/read; that write is dropped and that read does not advance the pointers.
- Boundaries:
  - Upsizing with a partial output beat stored: valid_rd stays 0 until enough words arrive.
  - Downsizing: level may be an odd multiple of WORDS_OUT.
  - Pointers wrap seamlessly. Ordering is preserved across the wrap.
  - level never exceeds DEPTH.
- almost_full and almost_empty are combinational from level.

Optional Feature:
SYNC_WIDTH_CONV_FIFO_LAST_EN
- When defined, adds ports last_wr (in, 1) and last_rd (out, 1), plus 1 sideband bit per storage word.
- last_wr is stored on the highest word of the input beat; the other words of the beat store 0.
- last_rd = OR of the sideband bits of the WORDS_OUT words of the current output beat.
- Upstream guarantees packet length is a multiple of WIDTH_OUT.
- flush also clears the sideband bits.
- When not defined: no ports, no sideband storage.

Test Plan:
- Reset: rst=1 -> ready_wr=0, valid_rd=0, level=0, almost_empty=1. After release, ready_wr=1 on the first cycle.
- Upsize (defaults): write 0x11111111 then 0x22222222 -> valid_rd=1 the next cycle, data_rd=0x2222222211111111, level=2. Read -> level=0, valid_rd=0.
- Full: 16 writes, no reads -> almost_full=1 at level 12, ready_wr=0 at level 16. A 17th valid_wr leaves level=16 and data unchanged.
- Simultaneous read and write at level 4 -> level=3 next cycle. Output data order is preserved.
- Flush at level 6 with valid_wr=1 and ready_rd=1 -> next cycle level=0, valid_rd=0, and the concurrent write is absent from later reads.
- Downsize instance (WIDTH_IN=64, WIDTH_OUT=32) with 40 words streamed continuously across pointer wraps -> output sequence equals input words LSB-first. With LAST_EN, last_rd=1 only on the final 32-bit word of the packet.

Source files
------------

// File: rtl/sync_width_conv_fifo.sv
// sync_width_conv_fifo: single-clock FIFO converting WIDTH_IN beats to WIDTH_OUT beats over BRAM_WIDTH words.
// Define SYNC_WIDTH_CONV_FIFO_LAST_EN to add last_wr/last_rd with one sideband bit per stored word.
module sync_width_conv_fifo #(
  parameter int WIDTH_IN   = 32,
  parameter int WIDTH_OUT  = 64,
  parameter int BRAM_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
`ifdef SYNC_WIDTH_CONV_FIFO_LAST_EN
  input  logic                       last_wr,
  output logic                       last_rd,
`endif
  input  logic [WIDTH_IN-1:0]        data_wr,
  input  logic                       valid_wr,
  output logic                       ready_wr,
  output logic [WIDTH_OUT-1:0]       data_rd,
  output logic                       valid_rd,
  input  logic                       ready_rd,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       almost_empty
);
  localparam int WORDS_IN  = WIDTH_IN / BRAM_WIDTH;
  localparam int WORDS_OUT = WIDTH_OUT / BRAM_WIDTH;
  localparam int AW        = $clog2(DEPTH);
  localparam int LW        = AW + 1;

  logic [BRAM_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wrptr;
  logic [AW-1:0]         r_rdptr;
  logic [LW-1:0]         r_level;
  logic                  w_wr;
  logic                  w_rd;

  assign ready_wr     = ~rst & (LW'(DEPTH) - r_level >= LW'(WORDS_IN));
  assign valid_rd     = ~rst & (r_level >= LW'(WORDS_OUT));
  assign w_wr         = valid_wr & ready_wr;
  assign w_rd         = valid_rd & ready_rd;
  assign level        = r_level;
  assign almost_full  = r_level >= LW'(AF_LEVEL);
  assign almost_empty = r_level <= LW'(AE_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wrptr <= r_wrptr + AW'(WORDS_IN);
      if (w_rd) r_rdptr <= r_rdptr + AW'(WORDS_OUT);
      r_level <= r_level + (w_wr ? LW'(WORDS_IN) : '0) - (w_rd ? LW'(WORDS_OUT) : '0);
    end
  end

  // Payload storage needs no reset; level gates every observation of it.
  always_ff @(posedge clk) begin
    if (w_wr & ~flush)
      for (int k = 0; k < WORDS_IN; k++)
        r_mem[r_wrptr + AW'(k)] <= data_wr[k*BRAM_WIDTH +: BRAM_WIDTH];
  end

  always_comb begin
    data_rd = '0;
    for (int j = 0; j < WORDS_OUT; j++)
      data_rd[j*BRAM_WIDTH +: BRAM_WIDTH] = r_mem[r_rdptr + AW'(j)];
  end

`ifdef SYNC_WIDTH_CONV_FIFO_LAST_EN
  logic [DEPTH-1:0] r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_last <= '0;
    else if (flush) r_last <= '0;
    else if (w_wr)
      for (int k = 0; k < WORDS_IN; k++)
        r_last[r_wrptr + AW'(k)] <= (k == WORDS_IN - 1) & last_wr;
  end

  always_comb begin
    last_rd = 1'b0;
    for (int j = 0; j < WORDS_OUT; j++)
      last_rd = last_rd | r_last[r_rdptr + AW'(j)];
  end
`endif
endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// tb_sync_width_conv_fifo: directed checks of an upsizing (32->64) and a downsizing (64->32) instance.
module tb_sync_width_conv_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        a_flush = 1'b0, a_valid_wr = 1'b0, a_ready_wr, a_valid_rd, a_ready_rd = 1'b0;
  logic [31:0] a_data_wr = '0;
  logic [63:0] a_data_rd;
  logic [4:0]  a_level;
  logic        a_af, a_ae;

  logic        b_flush = 1'b0, b_valid_wr = 1'b0, b_ready_wr, b_valid_rd, b_ready_rd = 1'b0;
  logic [63:0] b_data_wr = '0;
  logic [31:0] b_data_rd;
  logic [4:0]  b_level;
  logic        b_af, b_ae;
`ifdef SYNC_WIDTH_CONV_FIFO_LAST_EN
  logic        a_last_rd, b_last_wr = 1'b0, b_last_rd;
`endif

  always #5 clk = ~clk;

  sync_width_conv_fifo u_up (
    .clk(clk), .rst(rst), .flush(a_flush),
`ifdef SYNC_WIDTH_CONV_FIFO_LAST_EN
    .last_wr(1'b0), .last_rd(a_last_rd),
`endif
    .data_wr(a_data_wr), .valid_wr(a_valid_wr), .ready_wr(a_ready_wr),
    .data_rd(a_data_rd), .valid_rd(a_valid_rd), .ready_rd(a_ready_rd),
    .level(a_level), .almost_full(a_af), .almost_empty(a_ae)
  );

  sync_width_conv_fifo #(.WIDTH_IN(64), .WIDTH_OUT(32)) u_dn (
    .clk(clk), .rst(rst), .flush(b_flush),
`ifdef SYNC_WIDTH_CONV_FIFO_LAST_EN
    .last_wr(b_last_wr), .last_rd(b_last_rd),
`endif
    .data_wr(b_data_wr), .valid_wr(b_valid_wr), .ready_wr(b_ready_wr),
    .data_rd(b_data_rd), .valid_rd(b_valid_rd), .ready_rd(b_ready_rd),
    .level(b_level), .almost_full(b_af), .almost_empty(b_ae)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr_a(input logic [31:0] d);
    a_data_wr = d;
    a_valid_wr = 1'b1;
    cyc();
    a_valid_wr = 1'b0;
  endtask

  task automatic rd_a();
    a_ready_rd = 1'b1;
    cyc();
    a_ready_rd = 1'b0;
  endtask

  initial begin
    int wi, ri;
    cyc();
    chk("rst_ready_wr", 64'(a_ready_wr), 64'd0);
    chk("rst_valid_rd", 64'(a_valid_rd), 64'd0);
    chk("rst_level", 64'(a_level), 64'd0);
    chk("rst_almost_empty", 64'(a_ae), 64'd1);
    chk("rst_almost_full", 64'(a_af), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_wr", 64'(a_ready_wr), 64'd1);
    cyc();
    // Upsize: two 32-bit words form one 64-bit beat, oldest word in the LSBs
    wr_a(32'h1111_1111);
    chk("up_partial_valid", 64'(a_valid_rd), 64'd0);
    chk("up_partial_level", 64'(a_level), 64'd1);
    wr_a(32'h2222_2222);
    chk("up_valid", 64'(a_valid_rd), 64'd1);
    chk("up_data", a_data_rd, 64'h2222_2222_1111_1111);
    chk("up_level", 64'(a_level), 64'd2);
    chk("up_ae_at_2", 64'(a_ae), 64'd1);
    rd_a();
    chk("up_rd_level", 64'(a_level), 64'd0);
    chk("up_rd_valid", 64'(a_valid_rd), 64'd0);
    // Fill to DEPTH starting from pointer 2, so the fill wraps
    for (int i = 0; i < 16; i++) begin
      chk("fill_ready", 64'(a_ready_wr), 64'd1);
      wr_a(32'hA000_0000 + i);
      chk("fill_level", 64'(a_level), 64'(i + 1));
      if (i == 2) chk("ae_at_3", 64'(a_ae), 64'd0);
      if (i == 10) chk("af_at_11", 64'(a_af), 64'd0);
      if (i == 11) chk("af_at_12", 64'(a_af), 64'd1);
    end
    chk("full_ready", 64'(a_ready_wr), 64'd0);
    wr_a(32'hDEAD_BEEF);
    chk("full_overwrite_level", 64'(a_level), 64'd16);
    chk("full_overwrite_data", a_data_rd, 64'hA000_0001_A000_0000);
    for (int b = 0; b < 8; b++) begin
      chk("drain_data", a_data_rd, {32'hA000_0000 + 32'(2*b+1), 32'hA000_0000 + 32'(2*b)});
      rd_a();
    end
    chk("drain_level", 64'(a_level), 64'd0);
    // Simultaneous read and write at level 4
    for (int i = 0; i < 4; i++) wr_a(32'hB000_0000 + i);
    chk("sim_pre_data", a_data_rd, 64'hB000_0001_B000_0000);
    a_data_wr = 32'hB000_0004;
    a_valid_wr = 1'b1;
    a_ready_rd = 1'b1;
    cyc();
    a_valid_wr = 1'b0;
    a_ready_rd = 1'b0;
    chk("sim_level", 64'(a_level), 64'd3);
    chk("sim_data1", a_data_rd, 64'hB000_0003_B000_0002);
    rd_a();
    chk("sim_partial_valid", 64'(a_valid_rd), 64'd0);
    wr_a(32'hB000_0005);
    chk("sim_data2", a_data_rd, 64'hB000_0005_B000_0004);
    rd_a();
    // Flush at level 6 with concurrent write and read
    for (int i = 0; i < 6; i++) wr_a(32'hC000_0000 + i);
    chk("flush_pre_level", 64'(a_level), 64'd6);
    a_flush = 1'b1;
    a_data_wr = 32'hEEEE_EEEE;
    a_valid_wr = 1'b1;
    a_ready_rd = 1'b1;
    cyc();
    a_flush = 1'b0;
    a_valid_wr = 1'b0;
    a_ready_rd = 1'b0;
    chk("flush_level", 64'(a_level), 64'd0);
    chk("flush_valid", 64'(a_valid_rd), 64'd0);
    wr_a(32'hD000_0000);
    wr_a(32'hD000_0001);
    chk("flush_after_data", a_data_rd, 64'hD000_0001_D000_0000);
    rd_a();
    chk("flush_after_level", 64'(a_level), 64'd0);
    // Downsize: 20 beats (40 words) streamed with reader always ready
    wi = 0;
    ri = 0;
    b_ready_rd = 1'b1;
    for (int c = 0; c < 300 && ri < 40; c++) begin
      b_valid_wr = (wi < 20);
      b_data_wr = {32'h5000_0000 + 32'(2*wi+1), 32'h5000_0000 + 32'(2*wi)};
`ifdef SYNC_WIDTH_CONV_FIFO_LAST_EN
      b_last_wr = (wi == 19);
`endif
      #1;
      if (b_valid_rd) begin
        chk("dn_data", 64'(b_data_rd), 64'(32'h5000_0000 + 32'(ri)));
`ifdef SYNC_WIDTH_CONV_FIFO_LAST_EN
        chk("dn_last", 64'(b_last_rd), 64'(ri == 39));
`endif
        ri++;
      end
      if (b_valid_wr && b_ready_wr) wi++;
      chk("dn_level_bound", 64'(b_level <= 5'd16), 64'd1);
      cyc();
    end
    b_valid_wr = 1'b0;
    b_ready_rd = 1'b0;
    chk("dn_words_read", 64'(ri), 64'd40);
    chk("dn_end_level", 64'(b_level), 64'd0);
    chk("dn_end_valid", 64'(b_valid_rd), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
